// File: rtl/mips_mem_pkg.sv
// Shared types for the load/store unit: memory op codes, FSM states, latched request.
package mips_mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } mem_op_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } lsu_state_t;

    // Request as held for the duration of one operation; word doubles as the merged store word.
    typedef struct packed {
        mem_op_t             op;
        logic [WORD_W-1:0]   addr;
        logic [WORD_W-1:0]   word;
    } lsu_req_t;

    function automatic logic is_load(input mem_op_t op);
        return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
    endfunction

endpackage

// File: rtl/lsu_byte_align.sv
// Little-endian lane extraction with sign/zero extension for loads, and lane merge for sub-word stores.
module lsu_byte_align
    import mips_mem_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [1:0]        offset,
    input  logic [WORD_W-1:0] rdata,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data_c,
    output logic [WORD_W-1:0] store_word_c
);

    mem_op_t     op_e;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign op_e      = mem_op_t'(op);
    assign lane_byte = rdata[{offset, 3'b000} +: 8];
    // Halfword lane uses addr[1] only, so an odd halfword address silently aligns down.
    assign lane_half = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data_c = '0;
        case (op_e)
            LB:      load_data_c = {{24{lane_byte[7]}}, lane_byte};
            LBU:     load_data_c = {24'd0, lane_byte};
            LH:      load_data_c = {{16{lane_half[15]}}, lane_half};
            LHU:     load_data_c = {16'd0, lane_half};
            LW:      load_data_c = rdata;
            default: load_data_c = '0;
        endcase
    end

    always_comb begin
        store_word_c = rdata;
        case (op_e)
            SB: store_word_c[{offset, 3'b000} +: 8] = wdata[7:0];
            SH: begin
                if (offset[1]) begin
                    store_word_c[31:16] = wdata[15:0];
                end else begin
                    store_word_c[15:0] = wdata[15:0];
                end
            end
            SW:      store_word_c = wdata;
            default: store_word_c = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between datapath and a comb-read / posedge-write data memory.
// Optional LSU_MISALIGN_CHECK_EN: misaligned LH/LHU/SH/LW/SW become error responses.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              startin_n,
    input  logic              req_valid,
    input  logic [OP_W-1:0]   req_op,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [WORD_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_writeData,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [WORD_W-1:0] mem_readData
);

    localparam logic [30:0] WORD_LIMIT = 31'(MEM_WORDS);

    lsu_state_t        state, next_state;
    lsu_req_t          req_q, req_d;
    logic              valid_d, err_d, rd_d, wr_d;
    logic [WORD_W-1:0] rdata_d;
    mem_op_t           op_in;
    logic              range_err, misalign_err, req_bad;
    logic [WORD_W-1:0] load_data_c, store_word_c;

    assign op_in     = mem_op_t'(req_op);
    assign range_err = {1'b0, req_addr[31:2]} >= WORD_LIMIT;

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        case (op_in)
            LH, LHU, SH: misalign_err = req_addr[0];
            LW, SW:      misalign_err = |req_addr[1:0];
            default:     misalign_err = 1'b0;
        endcase
    end
`else
    assign misalign_err = 1'b0;
`endif

    assign req_bad       = range_err || misalign_err;
    assign req_ready     = (state == IDLE) && startin_n;
    assign mem_address   = {req_q.addr[31:2], 2'b00};
    assign mem_writeData = req_q.word;

    lsu_byte_align u_align (
        .op           (req_q.op),
        .offset       (req_q.addr[1:0]),
        .rdata        (mem_readData),
        .wdata        (req_q.word),
        .load_data_c  (load_data_c),
        .store_word_c (store_word_c)
    );

    // State and registered outputs; memory strobes are set on entry to the state that owns them.
    always_ff @(posedge clk) begin
        if (!startin_n) begin
            state        <= IDLE;
            req_q        <= '0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
            mem_memRead  <= 1'b0;
            mem_memWrite <= 1'b0;
        end else begin
            state        <= next_state;
            req_q        <= req_d;
            resp_valid   <= valid_d;
            resp_err     <= err_d;
            resp_rdata   <= rdata_d;
            mem_memRead  <= rd_d;
            mem_memWrite <= wr_d;
        end
    end

    always_comb begin
        next_state = state;
        req_d      = req_q;
        valid_d    = 1'b0;
        err_d      = resp_err;
        rdata_d    = resp_rdata;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    req_d.op   = op_in;
                    req_d.addr = req_addr;
                    req_d.word = req_wdata;
                    if (req_bad) begin
                        next_state = RESP;
                        valid_d    = 1'b1;
                        err_d      = 1'b1;
                        rdata_d    = '0;
                    end else if (is_load(op_in)) begin
                        next_state = LOAD;
                        rd_d       = 1'b1;
                    end else if (op_in == SW) begin
                        next_state = WRITE;
                        wr_d       = 1'b1;
                    end else begin
                        next_state = RMW_READ;
                        rd_d       = 1'b1;
                    end
                end
            end
            LOAD: begin
                next_state = RESP;
                valid_d    = 1'b1;
                err_d      = 1'b0;
                rdata_d    = load_data_c;
            end
            RMW_READ: begin
                next_state = WRITE;
                req_d.word = store_word_c;
                wr_d       = 1'b1;
            end
            WRITE: begin
                next_state = RESP;
                valid_d    = 1'b1;
                err_d      = 1'b0;
                rdata_d    = '0;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

endmodule
